serial_add_driver: RTL and testbench

Parallel-side front end for the bit-serial adder. Takes two WIDTH-bit operands on a start pulse and clears the adder's carry through its reset. Then shifts both operands out LSB-first, captures the returned sum stream and final carry into a WIDTH+1-bit result, and self-checks that result against a parallel reference sum. Sits between the register-level datapath and the serial adder core.

---
 rtl/serial_add_driver_if.sv | 29 ++
 rtl/serial_add_driver.sv | 127 ++++++++++++
 tb/tb_serial_add_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_add_driver_if.sv
// Handshake and serial-link bundle between the parallel datapath, the
// serial_add_driver front end and the bit-serial adder core.
interface serial_add_driver_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum_out;
  logic             mismatch;
  logic             ser_rst_n;
  logic             ser_a;
  logic             ser_b;
  logic             ser_s;
  logic             ser_c;

  // Driver-side view: operands in, serial bits out, serial result back in.
  modport slave (
    input  start, a_in, b_in, ser_s, ser_c,
    output busy, done, sum_out, mismatch, ser_rst_n, ser_a, ser_b
  );

  modport master (
    output start, a_in, b_in, ser_s, ser_c,
    input  busy, done, sum_out, mismatch, ser_rst_n, ser_a, ser_b
  );
endinterface

// File: rtl/serial_add_driver.sv
// Feeds two operands LSB-first into a bit-serial adder, reassembles the
// returned sum and carry, and flags any disagreement with a parallel add.
module serial_add_driver #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_add_driver_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] r_refA;
  logic [WIDTH-1:0] r_refB;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_cap;
  logic             r_busy;
  logic             r_done;
  logic             r_mismatch;
  logic [WIDTH:0]   r_sum;
  logic             r_serRstN;
  logic             r_serA;
  logic             r_serB;

  logic [CW-1:0]    w_capIdx;
  logic [WIDTH:0]   w_result;
  logic [WIDTH:0]   w_refSum;

  // The adder answers one cycle late, so DRAIN sees the top sum bit and carry.
  assign w_capIdx = r_cnt - 1'b1;
  assign w_result = {bus.ser_c, bus.ser_s, r_cap};
  assign w_refSum = {1'b0, r_refA} + {1'b0, r_refB};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shA      <= '0;
      r_shB      <= '0;
      r_refA     <= '0;
      r_refB     <= '0;
      r_cnt      <= '0;
      r_cap      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_sum      <= '0;
      r_serRstN  <= 1'b0;
      r_serA     <= 1'b0;
      r_serB     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done     <= 1'b0;
          r_mismatch <= 1'b0;
          r_serA     <= 1'b0;
          r_serB     <= 1'b0;
          if (bus.start) begin
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_serRstN <= 1'b0;
            r_shA     <= bus.a_in;
            r_shB     <= bus.b_in;
            r_refA    <= bus.a_in;
            r_refB    <= bus.b_in;
            r_cnt     <= '0;
            r_cap     <= '0;
          end else begin
            r_state   <= IDLE;
            r_serRstN <= 1'b1;
          end
        end
        CLEAR: begin
          r_state   <= SHIFT;
          r_serRstN <= 1'b1;
          r_serA    <= r_shA[0];
          r_serB    <= r_shB[0];
          r_shA     <= r_shA >> 1;
          r_shB     <= r_shB >> 1;
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_cap[w_capIdx] <= bus.ser_s;
          end
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DRAIN;
            r_serA  <= 1'b0;
            r_serB  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_serA <= r_shA[0];
            r_serB <= r_shB[0];
            r_shA  <= r_shA >> 1;
            r_shB  <= r_shB >> 1;
          end
        end
        DRAIN: begin
          r_state    <= DONE;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_sum      <= w_result;
          r_mismatch <= (w_result != w_refSum);
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum_out   = r_sum;
  assign bus.mismatch  = r_mismatch;
  assign bus.ser_rst_n = r_serRstN;
  assign bus.ser_a     = r_serA;
  assign bus.ser_b     = r_serB;
endmodule

// File: tb/tb_serial_add_driver.sv
// Directed bench for serial_add_driver with a behavioural bit-serial adder
// attached to the serial side (optionally with its sum line stuck at 0).
module tb_serial_add_driver;
  logic clk;
  logic reset;
  logic faultS0;
  logic modelS;
  logic modelC;
  int   checks;
  int   failures;

  serial_add_driver_if #(.WIDTH(8)) bus ();

  serial_add_driver #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered full adder with synchronous active-low clear of sum and carry.
  always @(posedge clk) begin
    if (!bus.ser_rst_n) begin
      modelS <= 1'b0;
      modelC <= 1'b0;
    end else begin
      modelS <= bus.ser_a ^ bus.ser_b ^ modelC;
      modelC <= (bus.ser_a & bus.ser_b) | (bus.ser_a & modelC) | (bus.ser_b & modelC);
    end
  end

  assign bus.ser_s = faultS0 ? 1'b0 : modelS;
  assign bus.ser_c = modelC;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
  endtask

  // Called at the negedge just before the start-sampling edge; returns at the DONE negedge.
  task automatic runToDone(input string tag, input logic [7:0] expA, input logic [7:0] expB,
                           input logic [8:0] expSum, input logic expMm, input bit chain,
                           input logic [7:0] nextA, input logic [7:0] nextB, input bit midPulse);
    int         n;
    int         clr;
    bit         got;
    logic [7:0] seqA;
    logic [7:0] seqB;
    n    = 0;
    clr  = 0;
    got  = 0;
    seqA = '0;
    seqB = '0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        checkOutput({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      end
      if (midPulse && n == 4) applyStimulus(8'hAA, 8'h55);
      if (midPulse && n == 5) bus.start = 1'b0;
      if (!bus.ser_rst_n) clr++;
      if (n >= 2 && n <= 9) begin
        seqA[n-2] = bus.ser_a;
        seqB[n-2] = bus.ser_b;
      end
      if (bus.done === 1'b1) got = 1;
    end
    checkOutput({tag, "_latency"}, n, 32'd11);
    checkOutput({tag, "_sum"}, {23'b0, bus.sum_out}, {23'b0, expSum});
    checkOutput({tag, "_mismatch"}, {31'b0, bus.mismatch}, {31'b0, expMm});
    checkOutput({tag, "_serA"}, {24'b0, seqA}, {24'b0, expA});
    checkOutput({tag, "_serB"}, {24'b0, seqB}, {24'b0, expB});
    checkOutput({tag, "_clears"}, clr, 32'd1);
    if (chain) applyStimulus(nextA, nextB);
  endtask

  task automatic checkIdleAfter(input string tag, input logic [8:0] expSum);
    @(negedge clk);
    checkOutput({tag, "_doneLow"}, {31'b0, bus.done}, 32'd0);
    checkOutput({tag, "_mmLow"}, {31'b0, bus.mismatch}, 32'd0);
    checkOutput({tag, "_idleBusy"}, {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, "_held"}, {23'b0, bus.sum_out}, {23'b0, expSum});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    faultS0   = 1'b0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'b0, bus.done}, 32'd0);
    checkOutput("rst_mismatch", {31'b0, bus.mismatch}, 32'd0);
    checkOutput("rst_sum", {23'b0, bus.sum_out}, 32'd0);
    checkOutput("rst_serRstN", {31'b0, bus.ser_rst_n}, 32'd0);
    checkOutput("rst_serAB", {30'b0, bus.ser_a, bus.ser_b}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rel_serRstN", {31'b0, bus.ser_rst_n}, 32'd1);

    $display("[TB] zero operands");
    applyStimulus(8'h00, 8'h00);
    runToDone("zero", 8'h00, 8'h00, 9'h000, 1'b0, 0, 8'h00, 8'h00, 0);
    checkIdleAfter("zero", 9'h000);

    $display("[TB] full carry ripple");
    applyStimulus(8'hFF, 8'h01);
    runToDone("ripple", 8'hFF, 8'h01, 9'h100, 1'b0, 0, 8'h00, 8'h00, 0);
    checkIdleAfter("ripple", 9'h100);

    $display("[TB] back-to-back");
    applyStimulus(8'h5A, 8'hA5);
    runToDone("b2b1", 8'h5A, 8'hA5, 9'h0FF, 1'b0, 1, 8'hFF, 8'hFF, 0);
    runToDone("b2b2", 8'hFF, 8'hFF, 9'h1FE, 1'b0, 0, 8'h00, 8'h00, 0);
    checkIdleAfter("b2b2", 9'h1FE);

    $display("[TB] start during shift");
    applyStimulus(8'h3C, 8'h0F);
    runToDone("ignore", 8'h3C, 8'h0F, 9'h04B, 1'b0, 0, 8'h00, 8'h00, 1);
    checkIdleAfter("ignore", 9'h04B);

    $display("[TB] reset mid-shift");
    applyStimulus(8'hFF, 8'h01);
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("abort_sum", {23'b0, bus.sum_out}, 32'd0);
    checkOutput("abort_serRstN", {31'b0, bus.ser_rst_n}, 32'd0);
    checkOutput("abort_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    checkOutput("abort_holdRstN", {31'b0, bus.ser_rst_n}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_relRstN", {31'b0, bus.ser_rst_n}, 32'd1);
    applyStimulus(8'h01, 8'h00);
    runToDone("postrst", 8'h01, 8'h00, 9'h001, 1'b0, 0, 8'h00, 8'h00, 0);
    checkIdleAfter("postrst", 9'h001);

    $display("[TB] sum line stuck at zero");
    faultS0 = 1'b1;
    applyStimulus(8'h01, 8'h00);
    runToDone("fault", 8'h01, 8'h00, 9'h000, 1'b1, 0, 8'h00, 8'h00, 0);
    checkIdleAfter("fault", 9'h000);
    faultS0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
